ehl_ahb_matrix_in: RTL and testbench
====================================

Name: ehl_ahb_matrix_in

Overview:
- Master-side input stage of the AHB matrix: one instance per master port, facing one AHB master.
- Decodes the master's address into a one-hot select over SNUM slave ports (matrix output stages).
- Broadcasts address/control/write data to all slave ports.
- Tracks which slave owns the current data phase and routes that slave's hrdata/hready/hresp back to the master.
- Contains a built-in default slave that gives a two-cycle ERROR response to unmapped accesses.

Parameters:
- SNUM, 4, number of slave ports (1..16).
- BASE, {SNUM{32'h0}}, packed SNUM*32 base addresses; slave s uses BASE[s*32+:32].
- MASK, {SNUM{32'hF000_0000}}, packed SNUM*32 compare masks; slave s matches when (haddr & MASK_s) == (BASE_s & MASK_s).

Ports:
- hclk  in  1  clock.
- hresetn  in  1  asynchronous active-low reset.
- im_haddr  in  32  master address.
- im_htrans  in  2  master transfer type.
- im_hwrite  in  1  master write.
- im_hsize  in  3  master size.
- im_hburst  in  3  master burst.
- im_hprot  in  4  master protection.
- im_hwdata  in  32  master write data.
- om_hrdata  out  32  read data to master.
- om_hready  out  1  ready to master.
- om_hresp  out  2  response to master.
- os_hsel  out  SNUM  one-hot slave-port select.
- os_haddr  out  32  address to slave ports.
- os_htrans  out  2  transfer type to slave ports.
- os_hwrite  out  1  write to slave ports.
- os_hsize  out  3  size to slave ports.
- os_hburst  out  3  burst to slave ports.
- os_hprot  out  4  protection to slave ports.
- os_hwdata  out  32  write data to slave ports.
- os_hready  out  1  HREADY-in to slave ports; equals om_hready.
- is_hrdata  in  SNUM*32  per-slave read data.
- is_hready  in  SNUM  per-slave ready.
- is_hresp  in  SNUM*2  per-slave response.

Behaviour:
- Address phase is combinational; no added latency.
  - os_haddr/htrans/hwrite/hsize/hburst/hprot = im_* unchanged.
  - os_hwdata = im_hwdata.
- Decode:
  - os_hsel[s]=1 for the lowest-index s that matches; all other bits 0.
  - Overlapping regions: lowest index wins.
  - hsel is driven independent of htrans; IDLE to a mapped slave still selects it.
- Unmapped: no match. os_hsel=0 and the access is directed to the internal default slave.
- Data-phase owner register dsel (SNUM+1 one-hot: slaves plus default):
  - Loaded from the decode result on every cycle om_hready=1.
  - Holds while om_hready=0.
  - The default bit is set only for an unmapped NONSEQ/SEQ.
  - Unmapped IDLE/BUSY loads dsel=0 (no owner).
- Response mux:
  - dsel=slave s: om_hrdata=is_hrdata[s], om_hready=is_hready[s], om_hresp=is_hresp[s].
  - dsel=0: om_hready=1, om_hresp=OKAY(00), om_hrdata=0.
  - dsel=default: driven by the error FSM; om_hrdata=0.
- Default-slave FSM with states D_IDLE, D_ERR1, D_ERR2:
  - D_IDLE -> D_ERR1 when om_hready=1 and the access is unmapped NONSEQ/SEQ.
  - D_ERR1: om_hready=0, om_hresp=ERROR(01); next state D_ERR2 unconditionally.
  - D_ERR2: om_hready=1, om_hresp=ERROR.
    - A new access presented in D_ERR2 is accepted: dsel reloads.
    - If that access is also unmapped NONSEQ/SEQ, next state is D_ERR1; otherwise D_IDLE.
  - A master changing htrans to IDLE during D_ERR1 does not shorten the response.
- Busy and IDLE transfers to a mapped slave are forwarded; the slave answers them (OKAY, zero wait per AHB).
- Reset, asynchronous, clears:
  - dsel=0 and FSM=D_IDLE.
  - Outputs: om_hready=1, om_hresp=00, om_hrdata=0.
  - os_hsel and forwarded signals follow the (reset-independent) inputs.
- Reset mid-transfer abandons the data phase; no pending error survives.
- X-safety: dsel and the FSM state never take a value outside one-hot/legal; any illegal state recovers to D_IDLE/dsel=0.

Test Plan:
1. SNUM=2, BASE={32'h1000_0000,32'h0}, MASK all F000_0000. NONSEQ read at 0x0000_0040 with is_hready[0]=1, is_hrdata[0]=32'hDEAD_BEEF -> os_hsel=2'b01 in the address cycle; next cycle om_hrdata=DEAD_BEEF, om_hready=1, om_hresp=00.
2. NONSEQ write at 0x1000_0004 followed by a read at 0x0000_0008; slave1 holds is_hready[1]=0 for 2 cycles -> om_hready=0 for 2 cycles; the read address stays presented; os_hsel=2'b01 and os_hready=0 during the stall; data then routes from slave0.
3. NONSEQ at 0x8000_0000 (unmapped) -> os_hsel=00; next cycle om_hready=0/hresp=01; following cycle om_hready=1/hresp=01; then back to OKAY.
4. Back-to-back unmapped NONSEQs with the second presented in D_ERR2 -> ERR1, ERR2, ERR1, ERR2 sequence with no OKAY cycle between.
5. IDLE at 0x8000_0000 -> om_hready=1, om_hresp=00 next cycle; FSM stays D_IDLE.
6. hresetn low during slave1 wait state -> om_hready=1, hresp=00, hrdata=0 immediately; after release, a read to slave0 completes normally.

Source files
------------

// File: rtl/ehl_ahb_matrix_in.sv
// Master-side input stage of the AHB matrix: decodes the master address onto SNUM slave ports,
// tracks the data-phase owner and returns its response, with a built-in ERROR default slave.
module ehl_ahb_matrix_in #(
    parameter int                 SNUM = 4,
    parameter logic [SNUM*32-1:0] BASE = {SNUM{32'h0}},
    parameter logic [SNUM*32-1:0] MASK = {SNUM{32'hF000_0000}}
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic [31:0]          im_haddr,
    input  logic [1:0]           im_htrans,
    input  logic                 im_hwrite,
    input  logic [2:0]           im_hsize,
    input  logic [2:0]           im_hburst,
    input  logic [3:0]           im_hprot,
    input  logic [31:0]          im_hwdata,
    output logic [31:0]          om_hrdata,
    output logic                 om_hready,
    output logic [1:0]           om_hresp,
    output logic [SNUM-1:0]      os_hsel,
    output logic [31:0]          os_haddr,
    output logic [1:0]           os_htrans,
    output logic                 os_hwrite,
    output logic [2:0]           os_hsize,
    output logic [2:0]           os_hburst,
    output logic [3:0]           os_hprot,
    output logic [31:0]          os_hwdata,
    output logic                 os_hready,
    input  logic [SNUM*32-1:0]   is_hrdata,
    input  logic [SNUM-1:0]      is_hready,
    input  logic [SNUM*2-1:0]    is_hresp
);

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } dstate_e;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    logic [SNUM-1:0] hsel;
    logic            unmapped_xfer;
    logic [SNUM:0]   dsel_d, dsel_q;
    logic            dsel_legal;
    dstate_e         state_d, state_q;
    logic            err_hready;
    logic [1:0]      err_hresp;
    logic            hready_m;

    // Address phase is a pure pass-through to every slave port.
    assign os_haddr  = im_haddr;
    assign os_htrans = im_htrans;
    assign os_hwrite = im_hwrite;
    assign os_hsize  = im_hsize;
    assign os_hburst = im_hburst;
    assign os_hprot  = im_hprot;
    assign os_hwdata = im_hwdata;

    // Scanning from the top down lets the lowest matching index overwrite the others.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        hsel = '0;
        for (int s = SNUM - 1; s >= 0; s--) begin
            if ((im_haddr & MASK[s*32 +: 32]) == (BASE[s*32 +: 32] & MASK[s*32 +: 32])) begin
                hsel    = '0;
                hsel[s] = 1'b1;
            end
        end
    end

    assign os_hsel       = hsel;
    assign unmapped_xfer = ~(|hsel) & im_htrans[1];
    assign dsel_legal    = $onehot0(dsel_q);

    // Default-slave FSM: output decode.
    always_comb begin
        err_hready = 1'b1;
        err_hresp  = RESP_OKAY;
        case (state_q)
            D_ERR1: begin
                err_hready = 1'b0;
                err_hresp  = RESP_ERROR;
            end
            D_ERR2: err_hresp = RESP_ERROR;
            default: ;
        endcase
    end

    // Response mux; a corrupted owner register behaves as "no owner".
    always_comb begin
        om_hrdata = '0;
        hready_m  = 1'b1;
        om_hresp  = RESP_OKAY;
        if (dsel_legal) begin
            for (int s = 0; s < SNUM; s++) begin
                if (dsel_q[s]) begin
                    om_hrdata = is_hrdata[s*32 +: 32];
                    hready_m  = is_hready[s];
                    om_hresp  = is_hresp[s*2 +: 2];
                end
            end
            if (dsel_q[SNUM]) begin
                hready_m = err_hready;
                om_hresp = err_hresp;
            end
        end
    end

    assign om_hready = hready_m;
    assign os_hready = hready_m;

    always_comb begin
        if (!dsel_legal)   dsel_d = '0;
        else if (hready_m) dsel_d = {unmapped_xfer, hsel};
        else               dsel_d = dsel_q;
    end

    // Default-slave FSM: next state. D_ERR2 completes, so it may accept a new access.
    always_comb begin
        state_d = D_IDLE;
        case (state_q)
            D_IDLE, D_ERR2: state_d = (hready_m && unmapped_xfer) ? D_ERR1 : D_IDLE;
            D_ERR1:         state_d = D_ERR2;
            default:        state_d = D_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dsel_q  <= '0;
            state_q <= D_IDLE;
        end else begin
            dsel_q  <= dsel_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_ehl_ahb_matrix_in.sv
// Bench for ehl_ahb_matrix_in: directed AHB scenarios plus random traffic, scored against a
// transaction-level model of decode, data-phase ownership and the two-cycle ERROR response.
module tb_ehl_ahb_matrix_in;

    localparam int SNUM = 3;
    // slave0 0x0xxx_xxxx, slave1 0x1xxx_xxxx, slave2 0x0..0x3 (overlaps 0 and 1, loses to them)
    localparam logic [SNUM*32-1:0] BASE = {32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [SNUM*32-1:0] MASK = {32'hC000_0000, 32'hF000_0000, 32'hF000_0000};

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

    logic                hclk = 1'b0;
    logic                hresetn;
    logic [31:0]         im_haddr, im_hwdata;
    logic [1:0]          im_htrans;
    logic                im_hwrite;
    logic [2:0]          im_hsize, im_hburst;
    logic [3:0]          im_hprot;
    logic [31:0]         om_hrdata;
    logic                om_hready;
    logic [1:0]          om_hresp;
    logic [SNUM-1:0]     os_hsel;
    logic [31:0]         os_haddr, os_hwdata;
    logic [1:0]          os_htrans;
    logic                os_hwrite;
    logic [2:0]          os_hsize, os_hburst;
    logic [3:0]          os_hprot;
    logic                os_hready;
    logic [SNUM*32-1:0]  is_hrdata;
    logic [SNUM-1:0]     is_hready;
    logic [SNUM*2-1:0]   is_hresp;

    always #5 hclk = ~hclk;

    ehl_ahb_matrix_in #(.SNUM(SNUM), .BASE(BASE), .MASK(MASK)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .im_haddr(im_haddr), .im_htrans(im_htrans), .im_hwrite(im_hwrite),
        .im_hsize(im_hsize), .im_hburst(im_hburst), .im_hprot(im_hprot), .im_hwdata(im_hwdata),
        .om_hrdata(om_hrdata), .om_hready(om_hready), .om_hresp(om_hresp),
        .os_hsel(os_hsel), .os_haddr(os_haddr), .os_htrans(os_htrans), .os_hwrite(os_hwrite),
        .os_hsize(os_hsize), .os_hburst(os_hburst), .os_hprot(os_hprot), .os_hwdata(os_hwdata),
        .os_hready(os_hready),
        .is_hrdata(is_hrdata), .is_hready(is_hready), .is_hresp(is_hresp)
    );

    typedef struct packed {
        logic [31:0]     rdata;
        logic            rdy;
        logic [1:0]      resp;
        logic [SNUM-1:0] hsel;
        logic [76:0]     fwd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Region table in priority order, independent of the packed parameters above.
    logic [31:0] m_base [SNUM] = '{32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
    logic [31:0] m_mask [SNUM] = '{32'hF000_0000, 32'hF000_0000, 32'hC000_0000};

    // Model state: owner -1 = none, 0..SNUM-1 = slave, SNUM = default slave.
    int          owner = -1;
    int          err_cycle = 0;
    logic [31:0] p_addr = '0;
    logic [1:0]  p_trans = IDLE;
    logic        p_rdy = 1'b1;

    task automatic check(input string name, input logic [76:0] act, input logic [76:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int s = 0; s < SNUM; s++)
            if ((a & m_mask[s]) == (m_base[s] & m_mask[s])) return s;
        return -1;
    endfunction

    // Advance the model across one clock edge using the cycle that just ended.
    task automatic model_step();
        int d;
        if (!hresetn) begin
            owner     = -1;
            err_cycle = 0;
        end else if (!p_rdy) begin
            if (owner == SNUM && err_cycle == 1) err_cycle = 2;
        end else begin
            d = decode(p_addr);
            if (d >= 0) begin
                owner = d;
            end else if (p_trans == NONSEQ || p_trans == SEQ) begin
                owner     = SNUM;
                err_cycle = 1;
            end else begin
                owner = -1;
            end
        end
    endtask

    task automatic drive_cycle(input logic [31:0] addr, input logic [1:0] trans, input logic wr,
                               input logic [SNUM-1:0] rdy, input logic rst_low);
        exp_t e;
        int   d;
        @(posedge hclk);
        model_step();
        #1;
        hresetn   = !rst_low;
        im_haddr  = addr;
        im_htrans = trans;
        im_hwrite = wr;
        im_hsize  = 3'($urandom);
        im_hburst = 3'($urandom);
        im_hprot  = 4'($urandom);
        im_hwdata = $urandom;
        is_hready = rdy;
        is_hresp  = (SNUM*2)'($urandom);
        for (int s = 0; s < SNUM; s++) is_hrdata[s*32 +: 32] = $urandom;
        if (rst_low) begin
            owner     = -1;
            err_cycle = 0;
        end
        d      = decode(addr);
        e.hsel = '0;
        if (d >= 0) e.hsel[d] = 1'b1;
        if (owner < 0) begin
            e.rdata = '0; e.rdy = 1'b1; e.resp = 2'b00;
        end else if (owner == SNUM) begin
            e.rdata = '0; e.rdy = (err_cycle != 1); e.resp = 2'b01;
        end else begin
            e.rdata = is_hrdata[owner*32 +: 32];
            e.rdy   = is_hready[owner];
            e.resp  = is_hresp[owner*2 +: 2];
        end
        e.fwd = {addr, trans, wr, im_hsize, im_hburst, im_hprot, im_hwdata};
        exp_q.push_back(e);
        p_addr  = addr;
        p_trans = trans;
        p_rdy   = e.rdy;
    endtask

    // Monitor: the DUT presents a response every cycle; compare it mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge hclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("om_hrdata", 77'(om_hrdata), 77'(e.rdata));
                check("om_hready", 77'(om_hready), 77'(e.rdy));
                check("om_hresp", 77'(om_hresp), 77'(e.resp));
                check("os_hready", 77'(os_hready), 77'(e.rdy));
                check("os_hsel", 77'(os_hsel), 77'(e.hsel));
                check("forward", {os_haddr, os_htrans, os_hwrite, os_hsize, os_hburst,
                                  os_hprot, os_hwdata}, e.fwd);
            end
        end
    end

    initial begin
        logic [SNUM-1:0] rdy;
        hresetn   = 1'b0;
        im_haddr  = '0; im_htrans = IDLE; im_hwrite = 1'b0; im_hsize = '0;
        im_hburst = '0; im_hprot  = '0;   im_hwdata = '0;
        is_hready = '1; is_hrdata = '0;   is_hresp  = '0;

        // Reset state
        drive_cycle(32'h0, IDLE, 1'b0, '1, 1'b1);
        drive_cycle(32'h0, IDLE, 1'b0, '1, 1'b1);
        // Read from slave0
        drive_cycle(32'h0000_0040, NONSEQ, 1'b0, '1, 1'b0);
        drive_cycle(32'hF000_0000, IDLE, 1'b0, '1, 1'b0);
        // Write to slave1 stalled two cycles while the next read is held
        drive_cycle(32'h1000_0004, NONSEQ, 1'b1, '1, 1'b0);
        drive_cycle(32'h0000_0008, NONSEQ, 1'b0, 3'b101, 1'b0);
        drive_cycle(32'h0000_0008, NONSEQ, 1'b0, 3'b101, 1'b0);
        drive_cycle(32'h0000_0008, NONSEQ, 1'b0, '1, 1'b0);
        drive_cycle(32'hF000_0000, IDLE, 1'b0, '1, 1'b0);
        // Single unmapped access, master drops to IDLE during ERR1
        drive_cycle(32'h8000_0000, NONSEQ, 1'b0, '1, 1'b0);
        drive_cycle(32'hF000_0000, IDLE, 1'b0, '1, 1'b0);
        drive_cycle(32'hF000_0000, IDLE, 1'b0, '1, 1'b0);
        drive_cycle(32'hF000_0000, IDLE, 1'b0, '1, 1'b0);
        // Back-to-back unmapped accesses
        drive_cycle(32'h8000_0000, NONSEQ, 1'b0, '1, 1'b0);
        drive_cycle(32'h9000_0000, NONSEQ, 1'b0, '1, 1'b0);
        drive_cycle(32'h9000_0000, NONSEQ, 1'b0, '1, 1'b0);
        drive_cycle(32'hF000_0000, IDLE, 1'b0, '1, 1'b0);
        drive_cycle(32'hF000_0000, IDLE, 1'b0, '1, 1'b0);
        drive_cycle(32'hF000_0000, IDLE, 1'b0, '1, 1'b0);
        // Unmapped IDLE and BUSY give no error
        drive_cycle(32'h8000_0000, IDLE, 1'b0, '1, 1'b0);
        drive_cycle(32'hA000_0000, BUSY, 1'b0, '1, 1'b0);
        drive_cycle(32'hF000_0000, IDLE, 1'b0, '1, 1'b0);
        // Overlapping regions and slave2
        drive_cycle(32'h3000_0010, NONSEQ, 1'b0, '1, 1'b0);
        drive_cycle(32'h2000_0000, SEQ, 1'b0, '1, 1'b0);
        drive_cycle(32'h1000_0000, SEQ, 1'b0, '1, 1'b0);
        drive_cycle(32'hF000_0000, IDLE, 1'b0, '1, 1'b0);
        // Reset during a slave1 wait state, then a normal read from slave0
        drive_cycle(32'h1000_0000, NONSEQ, 1'b0, '1, 1'b0);
        drive_cycle(32'h0000_0008, NONSEQ, 1'b0, 3'b101, 1'b1);
        drive_cycle(32'h0000_0008, NONSEQ, 1'b0, '1, 1'b0);
        drive_cycle(32'hF000_0000, IDLE, 1'b0, '1, 1'b0);

        // Random traffic, mostly-ready slaves, one asynchronous reset in the middle
        for (int i = 0; i < 600; i++) begin
            for (int s = 0; s < SNUM; s++) rdy[s] = ($urandom_range(0, 3) != 0);
            drive_cycle({4'($urandom_range(0, 15)), 28'($urandom)}, 2'($urandom),
                        1'($urandom), rdy, (i == 300));
        end
        drive_cycle(32'hF000_0000, IDLE, 1'b0, '1, 1'b0);

        repeat (4) begin
            if (exp_q.size() != 0) @(negedge hclk);
        end
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
